// File: rtl/tmp101_sample_sequencer_pkg.sv
// tmp101_sample_sequencer_pkg: sequencer state encoding and TMP101 12-bit temperature format
package tmp101_sample_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    ISSUE_GO  = 3'd2,
    WAIT_MSB  = 3'd3,
    WAIT_LSB  = 3'd4,
    PUBLISH   = 3'd5,
    ERROR     = 3'd6
  } state_t;
  localparam int FRAC_BITS = 4;
  localparam int TEMP_W = 12;
  function automatic logic [TEMP_W-1:0] to_raw(input logic [7:0] msb, input logic [7:0] lsb);
    return {msb, lsb[7 -: FRAC_BITS]};
  endfunction
endpackage

// File: rtl/tmp101_sample_sequencer_tick_counter.sv
// tmp101_sample_sequencer_tick_counter: modulo-MOD counter with enable, clear and terminal strobe
module tmp101_sample_sequencer_tick_counter #(
  parameter int MOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(MOD);
  localparam logic [W-1:0] LAST = W'(MOD - 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/tmp101_sample_sequencer.sv
// tmp101_sample_sequencer: periodic TMP101 read requests, byte assembly and temperature publishing
module tmp101_sample_sequencer
  import tmp101_sample_sequencer_pkg::*;
#(
  parameter int SAMPLE_TICKS  = 15000000,
  parameter int TIMEOUT_TICKS = 6000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic                 go,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic                 ack_error,
  output logic                 temp_valid,
  output logic [TEMP_W-1:0]    temp_raw,
  output logic [7:0]           temp_integer,
  output logic [FRAC_BITS-1:0] temp_fraction,
  output logic                 negative,
  output logic                 error_flag,
  output logic [7:0]           sample_count
);
  state_t state, state_n;
  logic [7:0] msb;
  logic sample_tick, timeout;
  logic waiting;
  assign waiting = state == WAIT_MSB || state == WAIT_LSB;
  tmp101_sample_sequencer_tick_counter #(.MOD(SAMPLE_TICKS)) u_sample (
    .clk(clk), .rst_n(rst_n), .en(enable), .clr(!enable), .tick(sample_tick)
  );
  tmp101_sample_sequencer_tick_counter #(.MOD(TIMEOUT_TICKS)) u_timeout (
    .clk(clk), .rst_n(rst_n), .en(waiting),
    .clr(state == ISSUE_GO || (state == WAIT_MSB && byte_valid)), .tick(timeout)
  );
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:      state_n = enable ? WAIT_TICK : IDLE;
      WAIT_TICK: state_n = !enable ? IDLE : sample_tick ? ISSUE_GO : WAIT_TICK;
      ISSUE_GO:  state_n = WAIT_MSB;
      WAIT_MSB:  state_n = ack_error ? ERROR : byte_valid ? WAIT_LSB : timeout ? ERROR : WAIT_MSB;
      WAIT_LSB:  state_n = ack_error ? ERROR : byte_valid ? PUBLISH : timeout ? ERROR : WAIT_LSB;
      PUBLISH:   state_n = enable ? WAIT_TICK : IDLE;
      ERROR:     state_n = enable ? WAIT_TICK : IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Outputs are decoded from the next state so each strobe lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      msb           <= '0;
      go            <= 1'b0;
      temp_valid    <= 1'b0;
      temp_raw      <= '0;
      temp_integer  <= '0;
      temp_fraction <= '0;
      negative      <= 1'b0;
      error_flag    <= 1'b0;
      sample_count  <= '0;
    end else begin
      go         <= state_n == ISSUE_GO;
      temp_valid <= state_n == PUBLISH;
      if (state == WAIT_MSB && state_n == WAIT_LSB) msb <= byte_data;
      if (state_n == PUBLISH) begin
        temp_raw      <= to_raw(msb, byte_data);
        temp_integer  <= msb;
        temp_fraction <= byte_data[7 -: FRAC_BITS];
        negative      <= msb[7];
        error_flag    <= 1'b0;
        sample_count  <= sample_count + 8'd1;
      end
      if (state_n == ERROR) error_flag <= 1'b1;
    end
endmodule
